// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: FSM state codes, coin values,
// product indices and the credit width.
package vend_pkg;

  localparam int CREDIT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  typedef logic [1:0] prod_t;

  localparam prod_t FRIES  = 2'd0;
  localparam prod_t BURGER = 2'd1;
  localparam prod_t EGG    = 2'd2;
  localparam prod_t COFFEE = 2'd3;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W-1:0] val;
    case (code)
      2'b00:   val = CREDIT_W'(1);
      2'b01:   val = CREDIT_W'(2);
      2'b10:   val = CREDIT_W'(5);
      default: val = CREDIT_W'(10);
    endcase
    return val;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Counts frame_tick pulses while start is high; done fires combinationally on the
// TERMINAL-th tick and the count wraps. Dropping start clears the count.
module frame_timer #(
  parameter int unsigned TERMINAL = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic start,
  output logic done
);

  localparam int unsigned CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

  logic [CW-1:0] count;

  assign done = start && frame_tick && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!start || done) begin
      count <= '0;
    end else if (frame_tick) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending FSM: coins, selection, buy/cancel, timed dispense and one-cycle change pulse.
// All outputs registered (one-cycle latency); VEND_HIGHLIGHT_BLINK_EN enables highlight blinking.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_0         = 3,
  parameter int unsigned PRICE_1         = 8,
  parameter int unsigned PRICE_2         = 5,
  parameter int unsigned PRICE_3         = 2,
  parameter int unsigned DISPENSE_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES    = 15
) (
  input  logic                clk_25,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                sel_next,
  input  logic                sel_prev,
  input  logic                buy,
  input  logic                cancel,
  output logic [1:0]          sel_idx,
  output logic                highlight_on,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state_out,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                dispense_active,
  output logic [1:0]          dispense_idx,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount
);

  state_t              state;
  logic [CREDIT_W-1:0] price_sel;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] credit_added;
  logic                in_menu;
  logic                dispense_done;

  assign state_out = state;
  assign in_menu   = (state == ST_IDLE) || (state == ST_CREDIT);

  always_comb begin
    price_sel = CREDIT_W'(PRICE_0);
    case (sel_idx)
      FRIES:   price_sel = CREDIT_W'(PRICE_0);
      BURGER:  price_sel = CREDIT_W'(PRICE_1);
      EGG:     price_sel = CREDIT_W'(PRICE_2);
      COFFEE:  price_sel = CREDIT_W'(PRICE_3);
      default: price_sel = CREDIT_W'(PRICE_0);
    endcase
  end

  // Carry bit of the 9-bit sum flags a coin that would overflow the credit register.
  assign coin_sum     = {1'b0, credit} + {1'b0, coin_value(coin_code)};
  assign coin_ok      = coin_valid && !coin_sum[CREDIT_W];
  assign credit_added = coin_ok ? coin_sum[CREDIT_W-1:0] : credit;

  frame_timer #(
    .TERMINAL (DISPENSE_FRAMES)
  ) u_dispense_timer (
    .clk        (clk_25),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (state == ST_DISPENSE),
    .done       (dispense_done)
  );

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      credit          <= '0;
      sel_idx         <= FRIES;
      dispense_idx    <= FRIES;
      coin_reject     <= 1'b0;
      insufficient    <= 1'b0;
      dispense_active <= 1'b0;
      change_valid    <= 1'b0;
      change_amount   <= '0;
    end else begin
      coin_reject   <= 1'b0;
      insufficient  <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= '0;
      case (state)
        ST_IDLE, ST_CREDIT: begin
          if (sel_next && !sel_prev) begin
            sel_idx <= sel_idx + 2'd1;
          end else if (sel_prev && !sel_next) begin
            sel_idx <= sel_idx - 2'd1;
          end
          if (coin_valid && !coin_ok) begin
            coin_reject <= 1'b1;
          end
          // Buy is judged on pre-coin credit; an accepted coin still lands.
          if (cancel && state == ST_CREDIT) begin
            state         <= ST_CHANGE;
            change_valid  <= 1'b1;
            change_amount <= credit_added;
            credit        <= '0;
          end else if (buy && state == ST_CREDIT && credit >= price_sel) begin
            state           <= ST_DISPENSE;
            dispense_active <= 1'b1;
            dispense_idx    <= sel_idx;
            credit          <= credit_added - price_sel;
          end else begin
            insufficient <= buy;
            credit       <= credit_added;
            if (coin_ok) begin
              state <= ST_CREDIT;
            end
          end
        end
        ST_DISPENSE: begin
          coin_reject <= coin_valid;
          if (dispense_done) begin
            dispense_active <= 1'b0;
            if (credit != '0) begin
              state         <= ST_CHANGE;
              change_valid  <= 1'b1;
              change_amount <= credit;
              credit        <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          coin_reject <= coin_valid;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VEND_HIGHLIGHT_BLINK_EN
  logic blink_done;

  frame_timer #(
    .TERMINAL (BLINK_FRAMES)
  ) u_blink_timer (
    .clk        (clk_25),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (in_menu),
    .done       (blink_done)
  );

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      highlight_on <= 1'b1;
    end else if (!in_menu) begin
      highlight_on <= 1'b1;
    end else if (blink_done) begin
      highlight_on <= ~highlight_on;
    end
  end
`else
  // Blink period is irrelevant here; highlight stays solid.
  assign highlight_on = 1'b1 | (BLINK_FRAMES == 0) | in_menu;
`endif

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL have parameter PRICE_0, default 3, meaning the price of product 0 (fries) in credit units.
REQ-002 The block SHALL have parameter PRICE_1, default 8, meaning the price of product 1 (hamburger).
REQ-003 The block SHALL have parameter PRICE_2, default 5, meaning the price of product 2 (egg).
REQ-004 The block SHALL have parameter PRICE_3, default 2, meaning the price of product 3 (coffee).
REQ-005 The block SHALL have parameter DISPENSE_FRAMES, default 60, meaning the dispense duration in frame_tick pulses.
REQ-006 The block SHALL have parameter BLINK_FRAMES, default 15, meaning the highlight half-period in frame_tick pulses.
REQ-007 The block SHALL have these ports (name, direction, width, meaning):
 - clk_25 in 1: pixel clock; the only clock.
 - rst in 1: reset, asynchronous, active-high.
 - frame_tick in 1: one-cycle pulse per video frame.
 - coin_valid in 1: one-cycle coin-insert pulse.
 - coin_code in 2: coin value, 00=1, 01=2, 10=5, 11=10.
 - sel_next in 1: one-cycle button pulse.
 - sel_prev in 1: one-cycle button pulse.
 - buy in 1: one-cycle button pulse.
 - cancel in 1: one-cycle button pulse.
 - sel_idx out 2: highlighted product.
 - highlight_on out 1: draw the highlight frame.
 - credit out 8: current credit.
 - state_out out 2: FSM state code for display.
 - coin_reject out 1: one-cycle pulse.
 - insufficient out 1: one-cycle pulse.
 - dispense_active out 1: level, high while dispensing.
 - dispense_idx out 2: product being dispensed.
 - change_valid out 1: one-cycle pulse.
 - change_amount out 8: valid with change_valid.

Function
REQ-008 The FSM SHALL have states IDLE=0, CREDIT=1, DISPENSE=2, CHANGE=3; state_out SHALL equal the current state code.
REQ-009 In IDLE and CREDIT, an accepted coin SHALL add its value to credit on the next edge; IDLE SHALL then move to CREDIT.
REQ-010 A coin whose sum would exceed 255 SHALL be rejected: credit is unchanged and coin_reject pulses on the next cycle.
REQ-011 Coins in DISPENSE or CHANGE SHALL be rejected with coin_reject.
REQ-012 sel_next SHALL increment sel_idx modulo 4 (3->0), and sel_prev SHALL decrement it modulo 4 (0->3); both asserted together SHALL leave sel_idx unchanged; selection SHALL be ignored in DISPENSE and CHANGE.
REQ-013 In CREDIT, buy with credit >= price(sel_idx) SHALL subtract the price, latch dispense_idx=sel_idx and enter DISPENSE; dispense_active SHALL rise on the next cycle.
REQ-014 buy with credit < price, or in IDLE, SHALL pulse insufficient and change nothing else.
REQ-015 When coin and buy arrive in the same cycle, buy SHALL be evaluated against the pre-coin credit; the coin SHALL still be added if it is accepted.
REQ-016 When cancel and buy arrive in the same cycle, cancel SHALL win.
REQ-017 In CREDIT, cancel SHALL enter CHANGE; cancel in IDLE, DISPENSE or CHANGE SHALL be ignored.
REQ-018 DISPENSE SHALL last exactly DISPENSE_FRAMES frame_tick pulses, then go to CHANGE if credit > 0, else to IDLE.
REQ-019 CHANGE SHALL last one cycle: change_valid=1, change_amount=credit, credit cleared to 0, next state IDLE.
REQ-020 Outside a change_valid pulse, change_amount SHALL be 0.
REQ-021 Buttons SHALL be ignored in DISPENSE and CHANGE, except as stated in REQ-017.

Reset
REQ-022 rst SHALL asynchronously force: state IDLE, credit 0, sel_idx 0, dispense_idx 0, all pulse outputs 0, dispense_active 0, change_amount 0, frame/blink counters 0, highlight_on 1.
REQ-023 Reset during DISPENSE SHALL abort the dispense with no change pulse; the credit is discarded.

Configuration
REQ-024 With macro VEND_HIGHLIGHT_BLINK_EN defined, highlight_on SHALL toggle every BLINK_FRAMES frame_tick pulses in IDLE and CREDIT and hold 1 elsewhere.
REQ-025 Without VEND_HIGHLIGHT_BLINK_EN, highlight_on SHALL be constant 1 and no blink counter SHALL exist.

Structure
REQ-026 Package vend_pkg SHALL hold the state encoding, the coin_code-to-value mapping, the product index constants (FRIES=0, BURGER=1, EGG=2, COFFEE=3) and an 8-bit credit width constant.
REQ-027 Sub-module frame_timer SHALL be used, with interface: frame_tick in, start in, terminal-count parameter, done pulse out; it is instanced for the dispense timer and, when enabled, for the blink timer.

Verification
REQ-028 Coins 10,10 then buy with sel_idx=1 -> credit 20->12, dispense_active for 60 ticks, then change_valid with amount 12, credit 0, state IDLE.
REQ-029 Credit 250 plus coin 10 -> coin_reject pulse, credit stays 250; plus coin 5 -> credit 255.
REQ-030 Credit 2, sel_idx=2, buy -> insufficient pulse, credit 2, state CREDIT.
REQ-031 sel_prev from 0 -> 3; sel_next from 3 -> 0; both together -> unchanged.
REQ-032 Credit 5 with cancel and buy in the same cycle -> CHANGE with amount 5, no dispense.
REQ-033 rst at dispense tick 30 -> all outputs at reset values immediately, no change_valid afterwards.
